// File: rtl/norm_grs_pkg.sv
// Shared definitions for the normalizer: FSM encoding, default widths and
// the bit layout of the rounder-input word Min.
package norm_grs_pkg;

  localparam int SIG_WD_DEF = 23;
  localparam int EXP_WD_DEF = 8;
  localparam int RAW_WD_DEF = 2 * (SIG_WD_DEF + 1);

  localparam int MIN_S_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RSHIFT = 2'd1,
    ST_LSHIFT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int min_hidden_bit(input int sig_wd);
    return sig_wd + 3;
  endfunction

endpackage

// File: rtl/norm_pack.sv
// Combinational packer: turns the working significand/exponent into the
// {hidden, fraction, G, R, S} word, the output exponent and the flags.
module norm_pack
  import norm_grs_pkg::*;
#(
  parameter int Significant_WD = SIG_WD_DEF,
  parameter int Exp_WD         = EXP_WD_DEF,
  parameter int Raw_WD         = 2 * (Significant_WD + 1)
) (
  input  logic                         [Raw_WD-2:0]         i_w,
  input  logic signed                  [Exp_WD+2:0]         i_e,
  output logic                         [Significant_WD+3:0] o_min,
  output logic                         [Exp_WD-1:0]         o_exp,
  output logic                                              o_zero,
  output logic                                              o_denorm,
  output logic                                              o_ovf
);

  localparam int EW = Exp_WD + 3;
  localparam int MW = Significant_WD + 4;
  localparam int HID = min_hidden_bit(Significant_WD);
  localparam logic signed [EW-1:0] E_OVF = EW'((2 ** Exp_WD) - 1);

  logic          w_nonzero;
  logic          w_ovf;
  logic [MW-1:0] w_min_raw;

  assign w_nonzero = |i_w;
  assign w_ovf     = (i_e >= E_OVF);
  assign w_min_raw = {i_w[Raw_WD-2:Raw_WD-Significant_WD-4],
                      |i_w[Raw_WD-Significant_WD-5:MIN_S_BIT]};

  // Zero results override everything; otherwise saturate the exponent on overflow.
  always_comb begin
    o_min    = '0;
    o_exp    = '0;
    o_zero   = 1'b0;
    o_denorm = 1'b0;
    o_ovf    = 1'b0;
    if (!w_nonzero) begin
      o_zero = 1'b1;
    end else begin
      o_min    = w_min_raw;
      o_denorm = ~w_min_raw[HID];
      o_ovf    = w_ovf;
      if (w_ovf) begin
        o_exp = '1;
      end else begin
        o_exp = i_e[Exp_WD-1:0];
      end
    end
  end

endmodule

// File: rtl/norm_grs.sv
// Iterative normalizer: shifts an unnormalized magnitude one bit per cycle
// until the hidden bit is set or the exponent hits the denormal floor.
module norm_grs
  import norm_grs_pkg::*;
#(
  parameter int Significant_WD = SIG_WD_DEF,
  parameter int Exp_WD         = EXP_WD_DEF,
  parameter int Raw_WD         = 2 * (Significant_WD + 1)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [Raw_WD-1:0]           Raw,
  input  logic [Exp_WD+1:0]           Exp_in,
  input  logic                        Sign_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [Significant_WD+3:0]   Min,
  output logic [Exp_WD-1:0]           Exp_out,
  output logic                        Sign_out,
  output logic                        zero_flag,
  output logic                        denorm_flag,
  output logic                        ovf_flag
);

  // One guard bit beyond the signed input so RSHIFT increments cannot wrap.
  localparam int EW = Exp_WD + 3;
  localparam int MW = Significant_WD + 4;
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic signed [EW-1:0] E_LO  = EW'(1 - Raw_WD);

  state_t                   r_state, w_state_nxt;
  logic [Raw_WD-1:0]        r_w, w_w_nxt;
  logic signed [EW-1:0]     r_e, w_e_nxt, w_e_in;
  logic                     r_sign, w_sign_nxt;
  logic                     r_in_ready, r_out_valid;
  logic [MW-1:0]            r_min, w_min;
  logic [Exp_WD-1:0]        r_exp, w_exp;
  logic                     r_zero, r_denorm, r_ovf;
  logic                     w_zero, w_denorm, w_ovf;

  assign w_e_in = {Exp_in[Exp_WD+1], Exp_in};

  // Next-state, working register and exponent update.
  always_comb begin
    w_state_nxt = r_state;
    w_w_nxt     = r_w;
    w_e_nxt     = r_e;
    w_sign_nxt  = r_sign;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_w_nxt    = Raw;
          w_e_nxt    = w_e_in;
          w_sign_nxt = Sign_in;
          if (Raw == '0) begin
            w_state_nxt = ST_DONE;
          end else if (w_e_in < E_LO) begin
            w_w_nxt     = {{(Raw_WD-1){1'b0}}, 1'b1};
            w_e_nxt     = E_ONE;
            w_state_nxt = ST_DONE;
          end else if (Raw[Raw_WD-1] || (w_e_in < E_ONE)) begin
            w_state_nxt = ST_RSHIFT;
          end else if (!Raw[Raw_WD-2] && (w_e_in > E_ONE)) begin
            w_state_nxt = ST_LSHIFT;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RSHIFT: begin
        w_w_nxt = {1'b0, r_w[Raw_WD-1:1]} | {{(Raw_WD-1){1'b0}}, r_w[0]};
        w_e_nxt = r_e + E_ONE;
        if (!w_w_nxt[Raw_WD-1] && (w_e_nxt >= E_ONE)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RSHIFT;
        end
      end
      ST_LSHIFT: begin
        w_w_nxt = {r_w[Raw_WD-2:0], 1'b0};
        w_e_nxt = r_e - E_ONE;
        if (w_w_nxt[Raw_WD-2] || (w_e_nxt == E_ONE)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_LSHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  norm_pack #(
    .Significant_WD (Significant_WD),
    .Exp_WD         (Exp_WD),
    .Raw_WD         (Raw_WD)
  ) u_pack (
    .i_w      (w_w_nxt[Raw_WD-2:0]),
    .i_e      (w_e_nxt),
    .o_min    (w_min),
    .o_exp    (w_exp),
    .o_zero   (w_zero),
    .o_denorm (w_denorm),
    .o_ovf    (w_ovf)
  );

  // State registers; result outputs are captured from the packer whenever DONE is next.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_w         <= '0;
      r_e         <= '0;
      r_sign      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_min       <= '0;
      r_exp       <= '0;
      r_zero      <= 1'b0;
      r_denorm    <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_w         <= w_w_nxt;
      r_e         <= w_e_nxt;
      r_sign      <= w_sign_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      if (w_state_nxt == ST_DONE) begin
        r_min    <= w_min;
        r_exp    <= w_exp;
        r_zero   <= w_zero;
        r_denorm <= w_denorm;
        r_ovf    <= w_ovf;
      end else begin
        r_min    <= r_min;
        r_exp    <= r_exp;
        r_zero   <= r_zero;
        r_denorm <= r_denorm;
        r_ovf    <= r_ovf;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign Min         = r_min;
  assign Exp_out     = r_exp;
  assign Sign_out    = r_sign;
  assign zero_flag   = r_zero;
  assign denorm_flag = r_denorm;
  assign ovf_flag    = r_ovf;

endmodule

// File: tb/tb_norm_grs.sv
// Directed table-driven bench for norm_grs with backpressure and reset corner sequences.
module tb_norm_grs;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] Raw;
  logic [9:0]  Exp_in;
  logic        Sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] Min;
  logic [7:0]  Exp_out;
  logic        Sign_out;
  logic        zero_flag;
  logic        denorm_flag;
  logic        ovf_flag;

  int n_cmp = 0;
  int n_bad = 0;

  norm_grs dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Raw         (Raw),
    .Exp_in      (Exp_in),
    .Sign_in     (Sign_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Min         (Min),
    .Exp_out     (Exp_out),
    .Sign_out    (Sign_out),
    .zero_flag   (zero_flag),
    .denorm_flag (denorm_flag),
    .ovf_flag    (ovf_flag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [47:0]        raw;
    logic signed [9:0]  ex;
    logic               sg;
    int                 lat;
    logic [26:0]        min;
    logic [7:0]         eo;
    logic               z;
    logic               d;
    logic               o;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one vector, optionally stall out_ready for 'hold' cycles, then retire it.
  task automatic run_vec(input int i, input int hold);
    int lat;
    @(negedge CLK);
    chk($sformatf("v%0d in_ready", i), {63'd0, in_ready}, 64'd1);
    in_valid  = 1'b1;
    Raw       = vecs[i].raw;
    Exp_in    = vecs[i].ex;
    Sign_in   = vecs[i].sg;
    out_ready = 1'b0;
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge CLK);
      lat++;
    end
    chk($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
    chk($sformatf("v%0d Min", i), {37'd0, Min}, {37'd0, vecs[i].min});
    chk($sformatf("v%0d Exp_out", i), {56'd0, Exp_out}, {56'd0, vecs[i].eo});
    chk($sformatf("v%0d Sign_out", i), {63'd0, Sign_out}, {63'd0, vecs[i].sg});
    chk($sformatf("v%0d flags", i), {61'd0, zero_flag, denorm_flag, ovf_flag},
        {61'd0, vecs[i].z, vecs[i].d, vecs[i].o});
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk($sformatf("v%0d hold%0d out_valid", i, h), {63'd0, out_valid}, 64'd1);
      chk($sformatf("v%0d hold%0d in_ready", i, h), {63'd0, in_ready}, 64'd0);
      chk($sformatf("v%0d hold%0d Min", i, h), {37'd0, Min}, {37'd0, vecs[i].min});
      chk($sformatf("v%0d hold%0d Exp_out", i, h), {56'd0, Exp_out}, {56'd0, vecs[i].eo});
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    chk($sformatf("v%0d retired out_valid", i), {63'd0, out_valid}, 64'd0);
    chk($sformatf("v%0d retired in_ready", i), {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic seen;
    //        raw                  exp_in   sg   lat  Min           Exp_out z     d     o
    vecs[0]  = '{48'h4000_0000_0000,  10'sd127, 1'b0, 1,  27'h4000000, 8'd127, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{48'h8000_0000_0001,  10'sd127, 1'b1, 2,  27'h4000001, 8'd128, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{48'h0000_0040_0000,  10'sd100, 1'b0, 25, 27'h4000000, 8'd76,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{48'h8000_0000_0000,  10'sd254, 1'b0, 2,  27'h4000000, 8'hFF,  1'b0, 1'b0, 1'b1};
    vecs[4]  = '{48'h4000_0000_0000, -10'sd2,   1'b1, 4,  27'h0800000, 8'd1,   1'b0, 1'b1, 1'b0};
    vecs[5]  = '{48'h0000_0000_0000,  10'sd50,  1'b1, 1,  27'h0000000, 8'd0,   1'b1, 1'b0, 1'b0};
    vecs[6]  = '{48'h0000_0000_1234, -10'sd100, 1'b0, 1,  27'h0000001, 8'd1,   1'b0, 1'b1, 1'b0};
    vecs[7]  = '{48'h0000_0000_0001,  10'sd5,   1'b0, 5,  27'h0000001, 8'd1,   1'b0, 1'b1, 1'b0};
    vecs[8]  = '{48'h4000_0000_0000, -10'sd47,  1'b0, 49, 27'h0000001, 8'd1,   1'b0, 1'b1, 1'b0};
    vecs[9]  = '{48'h2000_0000_0000,  10'sd1,   1'b1, 1,  27'h2000000, 8'd1,   1'b0, 1'b1, 1'b0};
    vecs[10] = '{48'h4000_0000_0000,  10'sd255, 1'b0, 1,  27'h4000000, 8'hFF,  1'b0, 1'b0, 1'b1};
    vecs[11] = '{48'h4000_0000_0000,  10'sd254, 1'b0, 1,  27'h4000000, 8'hFE,  1'b0, 1'b0, 1'b0};

    RST = 1'b1; in_valid = 1'b0; Raw = '0; Exp_in = '0; Sign_in = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset outputs", {28'd0, Min, Exp_out, Sign_out, zero_flag, denorm_flag, ovf_flag}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_vec(i, 0);
    end

    // Backpressure: result must stay put while out_ready is low.
    run_vec(1, 3);

    // Reset in the middle of a long LSHIFT run.
    @(negedge CLK);
    in_valid = 1'b1; Raw = vecs[2].raw; Exp_in = vecs[2].ex; Sign_in = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (5) @(negedge CLK);
    chk("mid-lshift busy", {63'd0, in_ready}, 64'd0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("post-rst in_ready", {63'd0, in_ready}, 64'd1);
    chk("post-rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("post-rst outputs", {28'd0, Min, Exp_out, Sign_out, zero_flag, denorm_flag, ovf_flag}, 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (out_valid) seen = 1'b1;
    end
    chk("no out_valid after rst", {63'd0, seen}, 64'd0);

    run_vec(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
